// File: rtl/sha_msg_sched.sv
// sha_msg_sched: SHA-256 message schedule generator producing W_t and K_t per round.
// Ports: usr_clk/usr_reset (async active-high), i_load+i_block capture a 512-bit block,
// i_cnt_en advances the round; o_wt/o_kt/o_round give the current round's words and index,
// o_cnt_flag marks round 63 in RUN, o_busy/o_done reflect RUN/DONE.
// Optional K ROM: define SHA_SCHED_KROM_EN to drive o_kt from the SHA-256 constant table.
module sha_msg_sched (
  input  logic         usr_clk,
  input  logic         usr_reset,
  input  logic         i_load,
  input  logic [511:0] i_block,
  input  logic         i_cnt_en,
  output logic [31:0]  o_wt,
  output logic [31:0]  o_kt,
  output logic [5:0]   o_round,
  output logic         o_cnt_flag,
  output logic         o_busy,
  output logic         o_done
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]  state;
  logic [5:0]  round;
  logic [31:0] w [16];
  logic [31:0] s0, s1, w_new;
  always_comb begin
    s0    = {w[1][6:0], w[1][31:7]} ^ {w[1][17:0], w[1][31:18]} ^ (w[1] >> 3);
    s1    = {w[14][16:0], w[14][31:17]} ^ {w[14][18:0], w[14][31:19]} ^ (w[14] >> 10);
    w_new = s1 + w[9] + s0 + w[0];
  end
  always_ff @(posedge usr_clk or posedge usr_reset) begin
    if (usr_reset) begin
      state <= IDLE;
      round <= 6'd0;
      for (int i = 0; i < 16; i++) w[i] <= 32'h0;
    end else if (state != RUN) begin
      if (i_load) begin
        state <= RUN;
        round <= 6'd0;
        for (int i = 0; i < 16; i++) w[i] <= i_block[511-32*i -: 32];
      end
    end else if (i_cnt_en) begin
      // The final advance leaves window and counter frozen on round 63.
      if (round == 6'd63) state <= DONE;
      else begin
        round <= round + 6'd1;
        for (int i = 0; i < 15; i++) w[i] <= w[i+1];
        w[15] <= w_new;
      end
    end
  end
  assign o_wt       = w[0];
  assign o_round    = round;
  assign o_cnt_flag = (state == RUN) && (round == 6'd63);
  assign o_busy     = state == RUN;
  assign o_done     = state == DONE;
`ifdef SHA_SCHED_KROM_EN
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  assign o_kt = (state == IDLE) ? 32'h0 : K[round];
`else
  assign o_kt = 32'h0;
`endif
endmodule

// File: tb/tb_sha_msg_sched.sv
// tb_sha_msg_sched: directed checks of sha_msg_sched with the padded "abc" block.
module tb_sha_msg_sched;
  logic         usr_clk = 1'b0;
  logic         usr_reset = 1'b1;
  logic         i_load = 1'b0;
  logic [511:0] i_block = '0;
  logic         i_cnt_en = 1'b0;
  logic [31:0]  o_wt, o_kt;
  logic [5:0]   o_round;
  logic         o_cnt_flag, o_busy, o_done;
  int           n_cmp = 0;
  int           n_err = 0;
  logic [31:0]  ref_w [64];
  logic [511:0] abc;
  sha_msg_sched dut (
    .usr_clk(usr_clk), .usr_reset(usr_reset), .i_load(i_load), .i_block(i_block),
    .i_cnt_en(i_cnt_en), .o_wt(o_wt), .o_kt(o_kt), .o_round(o_round),
    .o_cnt_flag(o_cnt_flag), .o_busy(o_busy), .o_done(o_done)
  );
  always #5 usr_clk = ~usr_clk;
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge usr_clk);
    #1;
  endtask
  initial begin
    logic [31:0] k0, k63;
`ifdef SHA_SCHED_KROM_EN
    k0 = 32'h428a2f98;
    k63 = 32'hc67178f2;
`else
    k0 = 32'h0;
    k63 = 32'h0;
`endif
    abc = {32'h61626380, 448'h0, 32'h00000018};
    for (int t = 0; t < 16; t++) ref_w[t] = abc[511-32*t -: 32];
    for (int t = 16; t < 64; t++)
      ref_w[t] = (rotr(ref_w[t-2], 17) ^ rotr(ref_w[t-2], 19) ^ (ref_w[t-2] >> 10)) + ref_w[t-7]
               + (rotr(ref_w[t-15], 7) ^ rotr(ref_w[t-15], 18) ^ (ref_w[t-15] >> 3)) + ref_w[t-16];
    tick();
    tick();
    chk("rst_wt", o_wt, 32'h0);
    chk("rst_kt", o_kt, 32'h0);
    chk("rst_round", {26'h0, o_round}, 32'h0);
    chk("rst_flags", {29'h0, o_cnt_flag, o_busy, o_done}, 32'h0);
    usr_reset = 1'b0;
    i_cnt_en = 1'b1;
    tick();
    tick();
    chk("idle_cnt_en_round", {26'h0, o_round}, 32'h0);
    chk("idle_cnt_en_busy", {31'h0, o_busy}, 32'h0);
    i_cnt_en = 1'b0;
    i_load = 1'b1;
    i_block = abc;
    tick();
    i_load = 1'b0;
    chk("r0_wt", o_wt, 32'h61626380);
    chk("r0_busy", {31'h0, o_busy}, 32'h1);
    chk("r0_round", {26'h0, o_round}, 32'h0);
    chk("r0_kt", o_kt, k0);
    i_cnt_en = 1'b1;
    repeat (15) tick();
    chk("r15_round", {26'h0, o_round}, 32'd15);
    chk("r15_wt", o_wt, 32'h00000018);
    tick();
    chk("r16_wt", o_wt, 32'h61626380);
    tick();
    chk("r17_wt", o_wt, 32'h000f0000);
    repeat (3) tick();
    chk("r20_round", {26'h0, o_round}, 32'd20);
    chk("r20_wt", o_wt, ref_w[20]);
    i_cnt_en = 1'b0;
    i_load = 1'b1;
    i_block = {16{32'hdeadbeef}};
    repeat (10) tick();
    i_load = 1'b0;
    chk("stall_round", {26'h0, o_round}, 32'd20);
    chk("stall_wt", o_wt, ref_w[20]);
    chk("stall_busy", {31'h0, o_busy}, 32'h1);
    i_cnt_en = 1'b1;
    for (int t = 21; t < 63; t++) begin
      tick();
      chk("run_wt", o_wt, ref_w[t]);
      chk("run_flag", {31'h0, o_cnt_flag}, 32'h0);
    end
    tick();
    chk("r63_round", {26'h0, o_round}, 32'd63);
    chk("r63_flag", {31'h0, o_cnt_flag}, 32'h1);
    chk("r63_wt", o_wt, ref_w[63]);
    chk("r63_kt", o_kt, k63);
    tick();
    chk("done_flags", {29'h0, o_cnt_flag, o_busy, o_done}, 32'h1);
    chk("done_round", {26'h0, o_round}, 32'd63);
    chk("done_wt", o_wt, ref_w[63]);
    chk("done_kt", o_kt, k63);
    repeat (3) tick();
    chk("done_hold_round", {26'h0, o_round}, 32'd63);
    chk("done_hold_done", {31'h0, o_done}, 32'h1);
    i_load = 1'b1;
    i_block = abc;
    tick();
    i_load = 1'b0;
    chk("reload_round", {26'h0, o_round}, 32'h0);
    chk("reload_wt", o_wt, 32'h61626380);
    chk("reload_busy", {31'h0, o_busy}, 32'h1);
    repeat (30) tick();
    chk("r30_round", {26'h0, o_round}, 32'd30);
    chk("r30_wt", o_wt, ref_w[30]);
    usr_reset = 1'b1;
    #1;
    chk("async_rst_wt", o_wt, 32'h0);
    chk("async_rst_kt", o_kt, 32'h0);
    chk("async_rst_round", {26'h0, o_round}, 32'h0);
    chk("async_rst_flags", {29'h0, o_cnt_flag, o_busy, o_done}, 32'h0);
    tick();
    usr_reset = 1'b0;
    i_cnt_en = 1'b0;
    tick();
    i_load = 1'b1;
    tick();
    i_load = 1'b0;
    chk("post_rst_round", {26'h0, o_round}, 32'h0);
    i_cnt_en = 1'b1;
    repeat (17) tick();
    chk("post_rst_r17_wt", o_wt, 32'h000f0000);
    chk("post_rst_r17_round", {26'h0, o_round}, 32'd17);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sha_msg_sched.md
SHA_MSG_SCHED -- requirements
Module: sha_msg_sched

Interface
REQ-001 The block SHALL have port usr_clk, input, 1 bit: system clock; all state updates on its rising edge.
REQ-002 The block SHALL have port usr_reset, input, 1 bit: reset, asynchronous and active-high.
REQ-003 The block SHALL have port i_load, input, 1 bit: request to capture a new 512-bit message block.
REQ-004 The block SHALL have port i_block, input, 512 bits: message block; word 0 = i_block[511:480] (big-endian word order).
REQ-005 The block SHALL have port i_cnt_en, input, 1 bit: round advance enable, driven by the SHA control unit.
REQ-006 The block SHALL have port o_wt, output, 32 bits: schedule word W_t for the current round.
REQ-007 The block SHALL have port o_kt, output, 32 bits: round constant K_t (see Configuration).
REQ-008 The block SHALL have port o_round, output, 6 bits: current round index t.
REQ-009 The block SHALL have port o_cnt_flag, output, 1 bit: last-round flag returned to the control unit.
REQ-010 The block SHALL have port o_busy, output, 1 bit: high while in RUN.
REQ-011 The block SHALL have port o_done, output, 1 bit: high while in DONE.

Function
REQ-012 The FSM SHALL have exactly the states IDLE, RUN and DONE, encoded in 2 bits.
REQ-013 In IDLE or DONE, i_load=1 SHALL capture i_block into a 16x32 window, clear the round counter to 0 and enter RUN on the next edge.
REQ-014 i_load SHALL be ignored in RUN; a new block is accepted only in IDLE or DONE.
REQ-015 If i_load and i_cnt_en are high on the same edge in IDLE or DONE, the load SHALL take effect and i_cnt_en SHALL be ignored.
REQ-016 In RUN, o_wt SHALL equal window[0], valid combinationally in the same cycle as o_round.
REQ-017 In RUN with i_cnt_en=1, each edge SHALL shift the window down one word, append the new word into window[15], and increment the round counter.
REQ-018 The appended word SHALL be sigma1(w[14]) + w[9] + sigma0(w[1]) + w[0], mod 2^32, where w[] is the window before the shift.
REQ-019 sigma0(x) SHALL be ROTR7 ^ ROTR18 ^ SHR3.
REQ-020 sigma1(x) SHALL be ROTR17 ^ ROTR19 ^ SHR10.
REQ-021 In RUN with i_cnt_en=0, the window, the round counter and o_wt SHALL hold (stall of any length).
REQ-022 o_cnt_flag SHALL be 1 exactly when state=RUN and round=63, and 0 otherwise.
REQ-023 In RUN with round=63 and i_cnt_en=1, the next state SHALL be DONE.
REQ-024 The round counter SHALL NOT wrap to 0 on that edge; it holds 63.
REQ-025 In DONE, o_done SHALL be 1, o_wt and o_round SHALL hold their last values, and the block SHALL wait for i_load.
REQ-026 i_cnt_en in IDLE or DONE SHALL have no effect.
REQ-027 o_busy SHALL be 1 only in RUN.

Reset
REQ-028 usr_reset=1 SHALL immediately force IDLE, clear the window and set o_round=0.
REQ-029 While usr_reset=1, o_wt, o_kt, o_cnt_flag, o_busy and o_done SHALL all be 0.
REQ-030 Assertion of usr_reset mid-RUN SHALL abort the block; no partial state survives.
REQ-031 After reset deassertion, the first accepted i_load SHALL start from round 0.

Configuration
REQ-032 With macro SHA_SCHED_KROM_EN defined, the block SHALL include a 64x32 ROM of the FIPS 180-4 SHA-256 constants.
REQ-033 With SHA_SCHED_KROM_EN defined, o_kt SHALL equal K[o_round] in RUN and DONE, and 0 in IDLE.
REQ-034 Without SHA_SCHED_KROM_EN, no ROM SHALL be built, o_kt SHALL be tied to 32'h0, and the port list SHALL be unchanged.

Verification
REQ-035 Reset, then load the padded "abc" block -> round 0: o_wt=0x61626380, o_busy=1; after 15 enables: o_wt=0x00000018.
REQ-036 Continue the "abc" block -> round 16: o_wt=0x61626380; round 17: o_wt=0x000F0000.
REQ-037 Continue to round 63 -> o_cnt_flag=1 in that cycle only; next edge: o_done=1, o_cnt_flag=0, o_round=63.
REQ-038 With SHA_SCHED_KROM_EN -> round 0: o_kt=0x428A2F98; round 63: o_kt=0xC67178F2. Without the macro -> o_kt=0 throughout.
REQ-039 Hold i_cnt_en=0 for 10 cycles at round 20 -> o_round and o_wt are unchanged; pulse i_load during RUN -> ignored.
REQ-040 Assert usr_reset at round 30 -> outputs are 0 and IDLE immediately; reload the same block -> round 17: o_wt=0x000F0000.
